mem_align_unit: RTL and testbench
=================================

Name: mem_align_unit

Overview:
- Memory-stage access unit sitting directly upstream of DataMemory. It takes one load/store request per cycle from the EX/MEM pipeline register and drives DataMemory's Address/WriteData/MemWrite/MemRead/ByteSel port.
- Aligned accesses pass through in one cycle. Misaligned half/word accesses are split into sequential byte accesses by an FSM, with Busy stalling the pipeline.
- Load data is assembled, then sign- or zero-extended; illegal requests are flagged.

Parameters:
- MEM_BYTES, 1024, size of DataMemory in bytes; any access touching a byte at or above it is an error.
- SPLIT_EN, 1, 1 = split misaligned accesses; 0 = flag them as Err with no memory access.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present this cycle.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 word, 11 half, 01 byte, 10 illegal (same encoding as DataMemory ByteSel).
- ReqSigned  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-justified.
- Busy  out  1  split in progress; the pipeline must hold its request.
- RespValid  out  1  one-cycle pulse: access complete (load or store).
- RespData  out  32  extended load data; 0 for stores and errors.
- Err  out  1  one-cycle pulse: illegal size, out of range, or misaligned with SPLIT_EN=0.
- MemAddress  out  32  to DataMemory Address.
- MemWriteData  out  32  to DataMemory WriteData.
- MemWrite  out  1  to DataMemory MemWrite; the write occurs at the Clk edge.
- MemRead  out  1  to DataMemory MemRead.
- MemByteSel  out  2  to DataMemory ByteSel.
- MemReadData  in  32  from DataMemory; combinational read, selected byte/half right-justified, upper bits ignored here.

Behaviour:
- Reset:
  - State IDLE.
  - Busy, RespValid, Err = 0; RespData = 0.
  - All Mem* outputs = 0; counter and latched request cleared.
- Byte order is little-endian: byte at address A+k occupies bits [8k+7:8k] of the value.
- Aligned rule: word needs addr[1:0]=0; half needs addr[0]=0; byte is always aligned.
- IDLE, aligned legal request (accept cycle T):
  - Mem* are driven combinationally in cycle T: MemAddress=ReqAddr, MemByteSel=ReqSize, MemWriteData=ReqWData, MemWrite=ReqWrite, MemRead=~ReqWrite.
  - Loads register the extended MemReadData at the T edge.
  - RespValid pulses in T+1; the state stays IDLE, so back-to-back requests are accepted every cycle.
- IDLE, misaligned legal request with SPLIT_EN=1:
  - In T, latch addr/size/signed/wdata/write; no memory access in T; go to SPLIT with k=0.
  - N = 4 for word, 2 for half.
- SPLIT, one byte access per cycle (T+1..T+N):
  - MemAddress = base+k, MemByteSel = 01.
  - Stores: MemWriteData = latched wdata[8k+7:8k] in bits [7:0].
  - Loads: MemReadData[7:0] is captured into assembly bits [8k+7:8k].
  - Busy = 1 throughout SPLIT; k increments each cycle.
  - After k = N-1, go to DONE.
- DONE (T+N+1):
  - RespValid = 1, RespData = extended assembled value, Busy = 0; return to IDLE.
  - A new request may be accepted in this same cycle.
- Extension:
  - byte signed: {24{d[7]}}, d[7:0].
  - half signed: {16{d[15]}}, d[15:0].
  - Unsigned extends with zeros; word is passed unchanged.
- Errors are checked in the accept cycle:
  - ReqSize = 10, or ReqAddr + bytes - 1 >= MEM_BYTES (computed in 33 bits, no wrap), or misaligned with SPLIT_EN=0.
  - Result: no Mem access, Err pulses in T+1, no RespValid, state stays IDLE.
- ReqValid while Busy is ignored and has no side effects.
- Rst during SPLIT aborts the access:
  - Bytes already written stay in memory; remaining bytes are not written.
  - No RespValid or Err is produced.
- Outside an access, all Mem* outputs are 0.

Test Plan:
- Reset, then aligned store word 0x00000004 @4, then load word @4 unsigned -> MemWrite=1 in cycle T with MemByteSel=00; RespValid at T+1; load RespData=0x00000004 one cycle after the load request, Busy never high.
- Misaligned store word 0x11223344 @5, then aligned byte loads @5..@8 unsigned -> Busy high 4 cycles, bytes written in order 0x44,0x33,0x22,0x11; loads return 0x44,0x33,0x22,0x11.
- Misaligned load word @5 signed after the previous scenario -> RespData=0x11223344, RespValid exactly 5 cycles after accept.
- Store byte 0xFF @33, then load byte @33 signed -> 0xFFFFFFFF; the same load unsigned -> 0x000000FF; misaligned load half @33 signed (byte @34 = 0x80) -> 0xFFFF80FF.
- ReqSize=10 @0, word @MEM_BYTES-2, and misaligned half @3 with SPLIT_EN=0 -> each gives Err pulse next cycle, MemWrite/MemRead stay 0, no RespValid.
- Rst asserted on the 2nd byte of a misaligned word store @9 of 0xAABBCCDD -> byte @9=0xDD written, bytes @10..@12 unchanged; after reset Busy=0 and RespValid=0.

Source files
------------

// File: rtl/mem_align_unit.sv
// Memory-stage access unit in front of DataMemory: passes aligned loads/stores,
// splits misaligned half/word accesses into byte accesses, extends load data.
// Ports: Clk/Rst; Req* request from EX/MEM; Busy stall; RespValid/RespData/Err
// response; Mem* drive DataMemory; MemReadData is its combinational read port.
module mem_align_unit #(
  parameter int MEM_BYTES = 1024,
  parameter bit SPLIT_EN  = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        Busy,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        Err,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [1:0]  MemByteSel,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t      state, stateNext;
  logic [31:0] baseAddr, wdataLat, asmData, respDataQ;
  logic [1:0]  sizeLat, cnt, lastK;
  logic        signedLat, writeLat, respValidQ, errQ;

  logic [2:0]  nBytes;
  logic [32:0] lastByte;
  logic [31:0] splitWData;
  logic        accept, misaligned, reqErr, doAligned, doSplit;

  function automatic logic [31:0] extend(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [31:0] r;
    unique case (sz)
      2'b01:   r = sg ? {{24{d[7]}}, d[7:0]} : {24'b0, d[7:0]};
      2'b11:   r = sg ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    unique case (ReqSize)
      2'b00:   nBytes = 3'd4;
      2'b11:   nBytes = 3'd2;
      default: nBytes = 3'd1;
    endcase
  end

  // End address in 33 bits so a request near 2^32 cannot wrap into range.
  assign lastByte = {1'b0, ReqAddr} + 33'(nBytes) - 33'd1;

  assign misaligned = (ReqSize == 2'b00 && ReqAddr[1:0] != 2'b00) ||
                      (ReqSize == 2'b11 && ReqAddr[0]);
  assign reqErr = (ReqSize == 2'b10) ||
                  (lastByte >= 33'(MEM_BYTES)) ||
                  (misaligned && !SPLIT_EN);

  // DONE may accept a new request; only SPLIT ignores ReqValid.
  assign accept    = ReqValid && !Rst && (state != SPLIT);
  assign doAligned = accept && !reqErr && !misaligned;
  assign doSplit   = accept && !reqErr && misaligned;

  assign lastK      = (sizeLat == 2'b00) ? 2'd3 : 2'd1;
  assign splitWData = wdataLat >> {cnt, 3'b000};

  always_comb begin
    MemAddress   = '0;
    MemWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    MemByteSel   = 2'b00;
    if (doAligned) begin
      MemAddress   = ReqAddr;
      MemWriteData = ReqWData;
      MemWrite     = ReqWrite;
      MemRead      = !ReqWrite;
      MemByteSel   = ReqSize;
    end else if (state == SPLIT && !Rst) begin
      // Gated by Rst so an aborted split writes no further bytes.
      MemAddress   = baseAddr + {30'b0, cnt};
      MemWriteData = {24'b0, splitWData[7:0]};
      MemWrite     = writeLat;
      MemRead      = !writeLat;
      MemByteSel   = 2'b01;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      SPLIT:   stateNext = (cnt == lastK) ? DONE : SPLIT;
      default: stateNext = doSplit ? SPLIT : IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      baseAddr   <= '0;
      wdataLat   <= '0;
      asmData    <= '0;
      respDataQ  <= '0;
      sizeLat    <= '0;
      cnt        <= '0;
      signedLat  <= 1'b0;
      writeLat   <= 1'b0;
      respValidQ <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      state      <= stateNext;
      respValidQ <= doAligned;
      errQ       <= accept && reqErr;
      respDataQ  <= (doAligned && !ReqWrite) ?
                    extend(MemReadData, ReqSize, ReqSigned) : 32'b0;
      if (doSplit) begin
        baseAddr  <= ReqAddr;
        wdataLat  <= ReqWData;
        sizeLat   <= ReqSize;
        signedLat <= ReqSigned;
        writeLat  <= ReqWrite;
        cnt       <= '0;
        asmData   <= '0;
      end else if (state == SPLIT) begin
        cnt <= cnt + 2'd1;
        if (!writeLat)
          asmData[{cnt, 3'b000} +: 8] <= MemReadData[7:0];
      end
    end
  end

  assign Busy      = (state == SPLIT);
  assign RespValid = respValidQ || (state == DONE);
  assign RespData  = (state == DONE) ?
                     (writeLat ? 32'b0 : extend(asmData, sizeLat, signedLat)) :
                     respDataQ;
  assign Err       = errQ;

endmodule

// File: tb/tb_mem_align_unit.sv
// Self-checking bench for mem_align_unit with a byte-array DataMemory model
// and a reference memory used to predict load results, errors and latency.
module tb_mem_align_unit;

  logic        Clk, Rst;
  logic        ReqValid, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqWData;
  logic        Busy, RespValid, Err, MemWrite, MemRead;
  logic [31:0] RespData, MemAddress, MemWriteData, MemReadData;
  logic [1:0]  MemByteSel;

  logic        v0, busy0, rv0, err0, mw0, mr0;
  logic [31:0] rd0, ma0, mwd0;
  logic [1:0]  mbs0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  dmem [0:1023];
  int          refMem [0:1023];
  logic [39:0] wlog [$];

  mem_align_unit #(.MEM_BYTES(1024), .SPLIT_EN(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .Busy(Busy), .RespValid(RespValid),
    .RespData(RespData), .Err(Err), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemByteSel(MemByteSel), .MemReadData(MemReadData)
  );

  mem_align_unit #(.MEM_BYTES(1024), .SPLIT_EN(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .ReqValid(v0), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .Busy(busy0), .RespValid(rv0),
    .RespData(rd0), .Err(err0), .MemAddress(ma0),
    .MemWriteData(mwd0), .MemWrite(mw0), .MemRead(mr0),
    .MemByteSel(mbs0), .MemReadData(32'h0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // DataMemory model: combinational read, write at the clock edge.
  // Upper bits of narrow reads carry junk the unit must ignore.
  logic [9:0]  ra;
  logic [31:0] rdAll;
  always_comb begin
    ra = MemAddress[9:0];
    rdAll = {dmem[ra + 10'd3], dmem[ra + 10'd2], dmem[ra + 10'd1], dmem[ra]};
    MemReadData = 32'h0;
    if (MemRead) begin
      if (MemByteSel == 2'b00)      MemReadData = rdAll;
      else if (MemByteSel == 2'b11) MemReadData = {16'hA5A5, rdAll[15:0]};
      else                          MemReadData = {24'hA5A5A5, rdAll[7:0]};
    end
  end

  always @(posedge Clk) begin
    if (MemWrite) begin
      int n;
      n = (MemByteSel == 2'b00) ? 4 : (MemByteSel == 2'b11) ? 2 : 1;
      for (int k = 0; k < n; k++)
        dmem[10'(MemAddress + 32'(k))] <= MemWriteData[8*k +: 8];
      if (MemByteSel == 2'b01)
        wlog.push_back({MemAddress, MemWriteData[7:0]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b11:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit refErr(input logic [1:0] sz, input logic [31:0] ad,
                                input bit splitEn);
    int n;
    n = sizeBytes(sz);
    if (n == 0) return 1'b1;
    if (longint'(ad) + n - 1 >= 1024) return 1'b1;
    if (!splitEn && (ad % 32'(n)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Little-endian value, then two's-complement reinterpretation if signed.
  function automatic logic [31:0] refLoad(input logic [31:0] ad, input int n,
                                          input bit sg);
    longint v;
    v = 0;
    for (int k = 0; k < n; k++)
      v += longint'(refMem[int'(ad) + k]) << (8 * k);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input bit junk, output logic [31:0] got);
    int n, lat, busyCnt;
    bit e, mis;
    logic [31:0] exp;
    int keep0;
    n = sizeBytes(sz);
    e = refErr(sz, ad, 1'b1);
    mis = !e && ((ad % 32'(n)) != 0);
    exp = (e || wr) ? 32'h0 : refLoad(ad, n, sg);
    keep0 = refMem[0];
    ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
    ReqAddr = ad; ReqWData = wd; ReqValid = 1'b1;
    #2;
    if (e || mis) begin
      chk("acceptMemWrite", 32'(MemWrite), 32'(0));
      chk("acceptMemRead", 32'(MemRead), 32'(0));
    end else begin
      chk("acceptAddr", MemAddress, ad);
      chk("acceptSel", 32'(MemByteSel), 32'(sz));
      chk("acceptWrite", 32'(MemWrite), 32'(wr));
      chk("acceptRead", 32'(MemRead), 32'(!wr));
      if (wr) chk("acceptWData", MemWriteData, wd);
    end
    tick();
    ReqValid = 1'b0;
    lat = 1;
    busyCnt = 0;
    while (!RespValid && !Err && lat < 12) begin
      busyCnt += int'(Busy);
      if (junk) begin
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00;
        ReqAddr = 32'h0; ReqWData = $urandom;
      end
      tick();
      lat++;
    end
    ReqValid = 1'b0;
    chk("latency", 32'(lat), 32'(mis ? n + 1 : 1));
    chk("busyCycles", 32'(busyCnt), 32'(mis ? n : 0));
    chk("busyAtResp", 32'(Busy), 32'(0));
    chk("err", 32'(Err), 32'(e));
    chk("respValid", 32'(RespValid), 32'(!e));
    chk("respData", RespData, exp);
    got = RespData;
    if (wr && !e) begin
      for (int k = 0; k < n; k++)
        refMem[int'(ad) + k] = int'((wd >> (8 * k)) & 32'hFF);
      for (int k = 0; k < n; k++)
        chk("memByte", 32'(dmem[int'(ad) + k]), 32'(refMem[int'(ad) + k]));
    end
    if (junk) chk("junkIgnored", 32'(dmem[0]), 32'(keep0));
  endtask

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 8'h00;
      refMem[i] = 0;
    end
    Rst = 1'b1; ReqValid = 1'b0; v0 = 1'b0; ReqWrite = 1'b0;
    ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = '0; ReqWData = '0;
    tick();
    tick();
    chk("rstBusy", 32'(Busy), 32'(0));
    chk("rstRespValid", 32'(RespValid), 32'(0));
    chk("rstErr", 32'(Err), 32'(0));
    chk("rstRespData", RespData, 32'h0);
    chk("rstMemAddr", MemAddress, 32'h0);
    chk("rstMemCtl", {28'b0, MemWrite, MemRead, MemByteSel}, 32'h0);
    Rst = 1'b0;
    tick();
    chk("idleMemWData", MemWriteData, 32'h0);

    issue(1, 2'b00, 0, 32'd4, 32'h4, 0, got);
    issue(0, 2'b00, 0, 32'd4, 32'h0, 0, got);
    chk("tpLoadWord4", got, 32'h4);

    wlog.delete();
    issue(1, 2'b00, 0, 32'd5, 32'h11223344, 0, got);
    chk("splitLogSize", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("splitW0", wlog[0], {32'd5, 8'h44});
      chk("splitW1", wlog[1], {32'd6, 8'h33});
      chk("splitW2", wlog[2], {32'd7, 8'h22});
      chk("splitW3", wlog[3], {32'd8, 8'h11});
    end
    issue(0, 2'b01, 0, 32'd5, 32'h0, 0, got); chk("tpB5", got, 32'h44);
    issue(0, 2'b01, 0, 32'd6, 32'h0, 0, got); chk("tpB6", got, 32'h33);
    issue(0, 2'b01, 0, 32'd7, 32'h0, 0, got); chk("tpB7", got, 32'h22);
    issue(0, 2'b01, 0, 32'd8, 32'h0, 0, got); chk("tpB8", got, 32'h11);
    issue(0, 2'b00, 1, 32'd5, 32'h0, 0, got); chk("tpW5", got, 32'h11223344);

    issue(1, 2'b01, 0, 32'd33, 32'hFF, 0, got);
    issue(0, 2'b01, 1, 32'd33, 32'h0, 0, got); chk("tpSB", got, 32'hFFFFFFFF);
    issue(0, 2'b01, 0, 32'd33, 32'h0, 0, got); chk("tpUB", got, 32'h000000FF);
    issue(1, 2'b01, 0, 32'd34, 32'h80, 0, got);
    issue(0, 2'b11, 1, 32'd33, 32'h0, 0, got); chk("tpSH", got, 32'hFFFF80FF);

    issue(1, 2'b10, 0, 32'd0, 32'h12345678, 0, got);
    issue(0, 2'b00, 0, 32'd1022, 32'h0, 0, got);
    issue(0, 2'b01, 0, 32'd1023, 32'h0, 0, got);
    issue(0, 2'b00, 0, 32'hFFFFFFFE, 32'h0, 0, got);

    ReqWrite = 1'b0; ReqSize = 2'b11; ReqAddr = 32'd3; v0 = 1'b1;
    #2;
    chk("noSplitMemWrite", 32'(mw0), 32'(0));
    chk("noSplitMemRead", 32'(mr0), 32'(0));
    chk("noSplitMemAddr", ma0 | mwd0 | 32'(mbs0), 32'h0);
    tick();
    v0 = 1'b0;
    chk("noSplitErr", 32'(err0), 32'(1));
    chk("noSplitRv", 32'(rv0), 32'(0));
    chk("noSplitBusy", 32'(busy0), 32'(0));
    chk("noSplitData", rd0, 32'h0);
    tick();
    chk("noSplitErrPulse", 32'(err0), 32'(0));

    wlog.delete();
    ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddr = 32'd9; ReqWData = 32'hAABBCCDD; ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    refMem[9] = 32'hDD;
    chk("abortBusy", 32'(Busy), 32'(0));
    chk("abortRv", 32'(RespValid), 32'(0));
    for (int a = 9; a <= 12; a++)
      chk("abortMem", 32'(dmem[a]), 32'(refMem[a]));
    chk("abortWrites", 32'(wlog.size()), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abortQuiet", {29'b0, Busy, RespValid, Err}, 32'h0);
    end

    for (int i = 0; i < 80; i++) begin
      int r;
      logic [1:0] sz;
      logic [31:0] ad;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b11 : (r < 9) ? 2'b01 : 2'b10;
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1015, 1023))
                                       : 32'($urandom_range(4, 48));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
            $urandom, 1'($urandom_range(0, 1)), got);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
